// File: rtl/lcd_text_seq_if.sv
// Host/driver-facing signal bundle of lcd_text_seq: text buffer writes, start/done
// handshake and the push port into the lcd_12864b write queue.
interface lcd_text_seq_if #(
  parameter int ROWS = 4,
  parameter int COLS = 16,
  parameter int QS   = 8
);
  localparam int AW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
  localparam int QW = (QS > 1) ? $clog2(QS) : 1;

  logic          start;
  logic          char_we;
  logic [AW-1:0] char_addr;
  logic [7:0]    char_data;
  logic          full;
  logic [7:0]    q_data;
  logic          q_cmd;
  logic          q_we;
  logic [QW-1:0] q_wptr;
  logic          busy;
  logic          done;

  modport master (
    output start, char_we, char_addr, char_data, full,
    input  q_data, q_cmd, q_we, q_wptr, busy, done
  );

  modport slave (
    input  start, char_we, char_addr, char_data, full,
    output q_data, q_cmd, q_we, q_wptr, busy, done
  );
endinterface

// File: rtl/lcd_text_seq.sv
// ST7920 (12864B) text sequencer: init bytes, per-row cursor address, then buffer text.
// Optional LCD_AUTO_PAGE_EN: endless page refresh with a timed clear between pages.
module lcd_text_seq #(
  parameter int ROWS       = 4,
  parameter int COLS       = 16,
  parameter int QS         = 8,
  parameter int CLEAR_WAIT = 300000,
  parameter int PAGE_DELAY = 300000
) (
  input logic         clk,
  input logic         rst_n,
  lcd_text_seq_if.slave bus
);
  localparam int AW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
  localparam int QW = (QS > 1) ? $clog2(QS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  if (ROWS < 1 || ROWS > 4 || COLS < 1 || COLS > 16 || QS < 1 ||
      CLEAR_WAIT < 1 || PAGE_DELAY < 1) begin : g_param_check
    $error("lcd_text_seq: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_POS   = 3'd2,
    S_DATA  = 3'd3,
    S_FIN   = 3'd4
`ifdef LCD_AUTO_PAGE_EN
    , S_WAIT  = 3'd5,
    S_CLEAR = 3'd6
`endif
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [2:0]    r_step;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [QW-1:0] r_wptr;
  logic [7:0]    r_buf [ROWS*COLS];

  logic          w_push;
  logic [7:0]    w_q_data;
  logic          w_q_cmd;
  logic          w_done;
  logic [7:0]    w_init_byte;
  logic [7:0]    w_base_byte;
  logic [AW-1:0] w_addr;
  logic          w_last_init;
  logic          w_last_col;
  logic          w_last_row;

  assign w_addr      = AW'(int'(r_row) * COLS + int'(r_col));
  assign w_last_init = (r_step == 3'd4);
  assign w_last_col  = (r_col == CW'(COLS - 1));
  assign w_last_row  = (r_row == RW'(ROWS - 1));

`ifdef LCD_AUTO_PAGE_EN
  localparam int DW = $clog2((PAGE_DELAY > CLEAR_WAIT ? PAGE_DELAY : CLEAR_WAIT) + 1);
  logic [DW-1:0] r_dly;
  logic          r_clr_sent;
  logic          w_dly_pg_end;
  logic          w_dly_clr_end;
  assign w_dly_pg_end  = (r_dly == DW'(PAGE_DELAY - 1));
  assign w_dly_clr_end = (r_dly == DW'(CLEAR_WAIT - 1));
`endif

  // Text buffer is not reset; a push reads it combinationally (old value on same-cycle write).
  always_ff @(posedge clk) begin
    if (bus.char_we) r_buf[bus.char_addr] <= bus.char_data;
  end

  always_comb begin
    case (r_step)
      3'd0:    w_init_byte = 8'h30;
      3'd1:    w_init_byte = 8'h0C;
      3'd2:    w_init_byte = 8'h30;
      3'd3:    w_init_byte = 8'h01;
      default: w_init_byte = 8'h06;
    endcase
    case (int'(r_row))
      0:       w_base_byte = 8'h80;
      1:       w_base_byte = 8'h90;
      2:       w_base_byte = 8'h88;
      default: w_base_byte = 8'h98;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_wptr  <= '0;
`ifdef LCD_AUTO_PAGE_EN
      r_dly      <= '0;
      r_clr_sent <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      if (w_push) r_wptr <= (r_wptr == QW'(QS - 1)) ? '0 : r_wptr + 1'b1;
      case (r_state)
        S_INIT: if (w_push) begin
          r_step <= w_last_init ? 3'd0 : r_step + 3'd1;
          r_row  <= '0;
        end
        S_POS: if (w_push) r_col <= '0;
        S_DATA: if (w_push) begin
          if (w_last_col) begin
            r_col <= '0;
            r_row <= w_last_row ? '0 : r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
`ifdef LCD_AUTO_PAGE_EN
        S_WAIT: r_dly <= w_dly_pg_end ? '0 : r_dly + 1'b1;
        // First the clear byte is pushed, then the LCD is given CLEAR_WAIT cycles to execute it.
        S_CLEAR: begin
          if (!r_clr_sent) begin
            if (w_push) r_clr_sent <= 1'b1;
          end else if (w_dly_clr_end) begin
            r_dly      <= '0;
            r_clr_sent <= 1'b0;
            r_row      <= '0;
          end else begin
            r_dly <= r_dly + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_state_next = S_INIT;
      S_INIT: if (w_push && w_last_init) w_state_next = S_POS;
      S_POS:  if (w_push) w_state_next = S_DATA;
      S_DATA: if (w_push && w_last_col) w_state_next = w_last_row ? S_FIN : S_POS;
`ifdef LCD_AUTO_PAGE_EN
      S_FIN:   w_state_next = S_WAIT;
      S_WAIT:  if (w_dly_pg_end) w_state_next = S_CLEAR;
      S_CLEAR: if (r_clr_sent && w_dly_clr_end) w_state_next = S_POS;
`else
      S_FIN:   w_state_next = S_IDLE;
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_push   = 1'b0;
    w_q_data = 8'h00;
    w_q_cmd  = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      S_INIT: begin
        w_push   = !bus.full;
        w_q_data = w_init_byte;
      end
      S_POS: begin
        w_push   = !bus.full;
        w_q_data = w_base_byte;
      end
      S_DATA: begin
        w_push   = !bus.full;
        w_q_data = r_buf[w_addr];
        w_q_cmd  = 1'b1;
      end
      S_FIN: w_done = 1'b1;
`ifdef LCD_AUTO_PAGE_EN
      S_CLEAR: if (!r_clr_sent) begin
        w_push   = !bus.full;
        w_q_data = 8'h01;
      end
`endif
      default: ;
    endcase
  end

  assign bus.q_data = w_q_data;
  assign bus.q_cmd  = w_q_cmd;
  assign bus.q_we   = w_push;
  assign bus.q_wptr = r_wptr;
  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = w_done;
endmodule

// File: doc/lcd_text_seq.md
Name: lcd_text_seq

Overview:
- Parametrised command/data sequencer for ST7920-class 128x64 character LCDs (12864B).
- Holds a ROWS x COLS character buffer and issues the power-up init sequence, then per-row cursor-address commands and character bytes.
- Pushes bytes into the pointer-addressed write queue of the lcd_12864b driver, honouring its full flag.
- Replaces hard-coded test-data loading with a host-writable text buffer and start/done handshake.

Parameters:
- ROWS, 4, displayed text rows, legal 1..4.
- COLS, 16, characters per row, legal 1..16.
- QS, 8, driver queue depth; sets q_wptr width ($clog2(QS)).
- CLEAR_WAIT, 300000, clk cycles idled after a clear command (LCD_AUTO_PAGE_EN only).
- PAGE_DELAY, 300000, clk cycles a page stays displayed before refresh (LCD_AUTO_PAGE_EN only).

Ports:
- clk, in, 1, sequencer clock; same clock as the driver.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle request to run init + full text write.
- char_we, in, 1, buffer write strobe.
- char_addr, in, $clog2(ROWS*COLS), row*COLS+col.
- char_data, in, 8, character code.
- full, in, 1, driver queue full.
- q_data, out, 8, byte to queue.
- q_cmd, out, 1, 0 = command (RS low), 1 = display data.
- q_we, out, 1, push strobe; one byte per asserted cycle.
- q_wptr, out, $clog2(QS), queue slot for the current push.
- busy, out, 1, high outside IDLE.
- done, out, 1, one-cycle pulse after the last character of a page is pushed.

Behaviour:
- Reset values: q_data=0, q_cmd=0, q_we=0, q_wptr=0, busy=0, done=0, state=IDLE, counters=0. Buffer contents are not reset. Reset mid-run aborts at once; the driver is reset together with the sequencer.
- Buffer: register array. char_we writes on the rising edge. A push reads combinationally, so a write to the same location in the push cycle sends the old value.
- States:
  - IDLE: start=1 -> INIT; start is ignored in all other states.
  - INIT: pushes 0x30, 0x0C, 0x30, 0x01, 0x06 (q_cmd=0) -> POS, row=0.
  - POS: pushes the row base address (q_cmd=0) from table 0x80, 0x90, 0x88, 0x98 -> DATA, col=0.
  - DATA: pushes buf[row*COLS+col] with q_cmd=1.
    - col wraps at COLS-1; then row+1 -> POS.
    - After the last row: done=1 for one cycle -> IDLE (or WAIT when LCD_AUTO_PAGE_EN is defined).
- Push rule: in a push state, with full=0, assert q_we with q_data/q_cmd/q_wptr valid that cycle. q_wptr increments modulo QS after each push (wraps QS-1 -> 0); sequence counters advance.
- With full=1, q_we=0 and nothing advances. full going high in the same cycle stalls that push.
- Latency: start in cycle N -> first push (0x30) in cycle N+1 if full=0. Uninterrupted run = 5 + ROWS*(COLS+1) push cycles.
- busy rises the cycle after start and falls with the return to IDLE (the cycle after done).

Optional Feature:
- Macro LCD_AUTO_PAGE_EN.
- Defined: states WAIT and CLEAR are added.
  - WAIT counts PAGE_DELAY cycles -> CLEAR.
  - CLEAR pushes 0x01 (q_cmd=0, stalls on full), then idles CLEAR_WAIT cycles -> POS with row=0, without init.
  - The page repeats until reset; done pulses at every page end; busy stays 1.
  - start is ignored.
- Undefined: WAIT/CLEAR and both delay counters are absent; end of page returns to IDLE and a new start is required.

Test Plan:
- Reset, ROWS=4, COLS=16, full=0, start pulse -> 73 pushes.
  - First five: 0x30, 0x0C, 0x30, 0x01, 0x06 with q_cmd=0.
  - Then 0x80 and 16 data bytes, repeated for rows with 0x90, 0x88, 0x98.
  - done pulses once; busy low the next cycle.
- Fill buffer with 0x41+index, run -> data bytes on row 2 are 0x61..0x70 in order, q_cmd=1.
- Hold full=1 for 10 cycles mid-DATA -> q_we=0, q_data and q_wptr frozen; resumes with the same byte when full drops.
- QS=8 -> q_wptr sequence 0..7, 0 across pushes 8->9.
- Second start pulse at push 20 is ignored. Assert rst_n=0 at push 40 -> all outputs 0 asynchronously; a post-reset start restarts from 0x30.
- LCD_AUTO_PAGE_EN with PAGE_DELAY=100, CLEAR_WAIT=50 -> after done, 100 idle cycles, push 0x01, 50 idle cycles, push 0x80, no init bytes.
